adder_share_arbiter: RTL

- Shares one 4-bit adder instance (kogge_stone_adder_4bit) between NUM_REQ requesters.
- Round-robin arbitration, one operation in flight at a time.
- Drives the adder operands, waits out the adder's pipeline latency, then returns sum and carry tagged with the requester ID over a valid/ready response channel.
- Sits between requester logic and the adder in the top-level datapath.

---
 rtl/adder_share_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// Shares one external 4-bit adder between NUM_REQ requesters: round-robin grant,
// one operation in flight, result returned over a valid/ready channel.
// Optional ADDER_SHARE_STATS_EN adds saturating grant_cnt / busy_cnt outputs.
module adder_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int ADDER_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [3:0]           rsp_sum,
    output logic                 rsp_cout
`ifdef ADDER_SHARE_STATS_EN
    ,
    output logic [15:0]          grant_cnt,
    output logic [15:0]          busy_cnt
`endif
);

    localparam int CNT_W = (ADDER_LAT < 1) ? 1 : $clog2(ADDER_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       opa_q, opa_d;
    logic [3:0]       opb_q, opb_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [3:0]       rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;

    // Rotate the valid vector so bit k is requester (rr_ptr + k) mod NUM_REQ;
    // the lowest set bit is then the round-robin winner.
    logic [2*NUM_REQ-1:0] vv;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W-1:0]      off;
    logic [ID_W:0]        idx_sum;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_vld;
    logic [NUM_REQ-1:0]   grant_oh;

    assign vv  = {req_valid, req_valid} >> rr_ptr_q;
    assign rot = vv[NUM_REQ-1:0];

    always_comb begin
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = ID_W'(k);
        end
    end

    assign grant_vld = |rot;
    assign idx_sum   = {1'b0, rr_ptr_q} + {1'b0, off};
    assign grant_idx = (idx_sum >= (ID_W+1)'(NUM_REQ))
                       ? ID_W'(idx_sum - (ID_W+1)'(NUM_REQ))
                       : ID_W'(idx_sum);
    assign grant_oh  = NUM_REQ'(1) << grant_idx;

    // Grant is offered combinationally, only while idle and out of reset.
    assign req_ready = (state_q == IDLE && !rst && grant_vld) ? grant_oh : '0;

    assign add_a = (state_q == BUSY) ? opa_q : 4'd0;
    assign add_b = (state_q == BUSY) ? opb_q : 4'd0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    opa_d   = req_a[4*grant_idx +: 4];
                    opb_d   = req_b[4*grant_idx +: 4];
                    id_d    = grant_idx;
                    cnt_d   = CNT_W'(ADDER_LAT);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_sum_d   = add_sum;
                    rsp_cout_d  = add_cout;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0
                                  : ID_W'(rsp_id_q + 1'b1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

`ifdef ADDER_SHARE_STATS_EN
    logic [15:0] grant_cnt_q, busy_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q <= '0;
            busy_cnt_q  <= '0;
        end else begin
            if (|(req_valid & req_ready) && grant_cnt_q != 16'hFFFF)
                grant_cnt_q <= grant_cnt_q + 16'd1;
            if (state_q != IDLE && busy_cnt_q != 16'hFFFF)
                busy_cnt_q <= busy_cnt_q + 16'd1;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign busy_cnt  = busy_cnt_q;
`endif

endmodule
